// File: rtl/shift_add_multiplier.sv
// ---------------------------------------------------------------------------
// shift_add_multiplier
//
// Sequential 8x8 unsigned multiplier that produces a 16-bit product. It adds
// one partial product per clock using the 8-bit ripple_carry_adder, which is
// also defined in this file.
//
// The accumulator A and the multiplicand M drive the adder's a/b inputs, with
// cin tied 0. The sum and carry are consumed combinationally in the same CALC
// cycle: add and right shift complete on one edge.
//
// Ports:
//   clk      in   1   rising-edge clock
//   rst      in   1   asynchronous active-high reset (aborts any operation)
//   start    in   1   operation request, sampled only in IDLE
//   a        in   8   multiplicand, captured with an accepted start
//   b        in   8   multiplier, captured with an accepted start
//   busy     out  1   high while iterating (CALC)
//   done     out  1   one-cycle pulse; product valid from this cycle on
//   product  out 16   registered result, held until the next run completes
//
// Optional feature macro: MUL_ZERO_SKIP_EN
//   When defined, a start with a==0 or b==0 goes straight to DONE with
//   product 0. busy stays low and done follows one edge after the accept.
//   When undefined, zero operands take the normal 8-iteration path.
// ---------------------------------------------------------------------------

module ripple_carry_adder (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);
    always_comb begin
        logic carry;
        carry = cin;
        sum   = '0;
        for (int i = 0; i < 8; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end
endmodule

module shift_add_multiplier #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    // The datapath is hard-wired to the 8-bit adder.
    generate
        if (WIDTH != 8) begin : g_bad_width
            $error("shift_add_multiplier: only WIDTH=8 is supported");
        end
        if ((1 << CNT_W) <= WIDTH) begin : g_bad_cnt
            $error("shift_add_multiplier: CNT_W too small for WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [WIDTH-1:0]   r_m;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_q;
    logic               r_c;
    logic [CNT_W-1:0]   r_cnt;

    logic [7:0]         w_sum;
    logic               w_cout;
    logic               w_add_c;
    logic [WIDTH-1:0]   w_add_a;
    logic [WIDTH-1:0]   w_a_next;
    logic [WIDTH-1:0]   w_q_next;
    logic               w_last;

    ripple_carry_adder u_rca (
        .a    (r_a),
        .b    (r_m),
        .cin  (1'b0),
        .sum  (w_sum),
        .cout (w_cout)
    );

    // One iteration step: conditional add, then shift {C,A,Q} right by one.
    // C is always 0 after a shift, so the no-add path {C,A} is {0,A}.
    always_comb begin
        w_add_c = r_c;
        w_add_a = r_a;
        if (r_q[0]) begin
            w_add_c = w_cout;
            w_add_a = w_sum;
        end
        w_a_next = {w_add_c, w_add_a[WIDTH-1:1]};
        w_q_next = {w_add_a[0], r_q[WIDTH-1:1]};
        w_last   = (r_cnt == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
`ifdef MUL_ZERO_SKIP_EN
                    if ((a == '0) || (b == '0)) begin
                        w_state_next = S_DONE;
                    end else begin
                        w_state_next = S_CALC;
                    end
`else
                    w_state_next = S_CALC;
`endif
                end
            end
            S_CALC: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m     <= '0;
            r_a     <= '0;
            r_q     <= '0;
            r_c     <= 1'b0;
            r_cnt   <= '0;
            product <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_m   <= a;
                        r_q   <= b;
                        r_a   <= '0;
                        r_c   <= 1'b0;
                        r_cnt <= '0;
`ifdef MUL_ZERO_SKIP_EN
                        if ((a == '0) || (b == '0)) begin
                            product <= '0;
                        end
`endif
                    end
                end
                S_CALC: begin
                    r_a   <= w_a_next;
                    r_q   <= w_q_next;
                    r_c   <= 1'b0;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        product <= {w_a_next, w_q_next};
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
